// File: rtl/uop_store.sv
// Microcode store: zero-filled on reset/restart, loaded from a 32-bit beat stream
// (three beats per entry), read combinationally by the microcode unit.
`timescale 1ns / 1ps

`ifndef UOP_BUF_SIZE
  `define UOP_BUF_SIZE 128
`endif
`ifndef MAX_PREDICT_DEPTH_BITS
  `define MAX_PREDICT_DEPTH_BITS 2
`endif
`ifndef UOP_BUF_WIDTH
  `define UOP_BUF_WIDTH (2*`MAX_PREDICT_DEPTH_BITS+64)
`endif

module uop_store #(
  parameter int unsigned UOP_BUF_SIZE           = `UOP_BUF_SIZE,
  parameter int unsigned MAX_PREDICT_DEPTH_BITS = `MAX_PREDICT_DEPTH_BITS,
  parameter int unsigned UOP_BUF_WIDTH          = `UOP_BUF_WIDTH,
  parameter int unsigned AW                     = $clog2(UOP_BUF_SIZE)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [AW-1:0]            uop_addr_i,
  output logic [UOP_BUF_WIDTH-1:0] uop_o,
  input  logic                     ld_valid_i,
  output logic                     ld_ready_o,
  input  logic [31:0]              ld_data_i,
  input  logic                     ld_last_i,
  input  logic                     ld_restart_i,
  output logic                     init_done_o,
  output logic                     load_done_o,
  output logic                     load_err_o,
  output logic [AW:0]              entry_count_o
);

  localparam int unsigned TagW = 2 * MAX_PREDICT_DEPTH_BITS;
  localparam logic [AW-1:0] LastIdx = AW'(UOP_BUF_SIZE - 1);

  typedef enum logic [1:0] {StClear, StLoad, StDone} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       clr_ptr_q, clr_ptr_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]          phase_q, phase_d;
  logic [AW:0]         entry_count_q, entry_count_d;
  logic                load_err_q, load_err_d;
  logic [TagW-1:0]     tag_q, tag_d;
  logic [31:0]         in1_q, in1_d;

  logic                     mem_we;
  logic [AW-1:0]            mem_waddr;
  logic [UOP_BUF_WIDTH-1:0] mem_wdata;
  logic [UOP_BUF_WIDTH-1:0] mem_q [UOP_BUF_SIZE];

  logic hs;

  assign ld_ready_o    = (state_q == StLoad);
  assign init_done_o   = (state_q != StClear);
  assign load_done_o   = (state_q == StDone);
  assign load_err_o    = load_err_q;
  assign entry_count_o = entry_count_q;
  assign hs            = ld_valid_i & ld_ready_o;

  // Array contents are stale while clearing, so the read port is forced to zero.
  assign uop_o = (state_q == StClear) ? '0 : mem_q[uop_addr_i];

  always_comb begin
    state_d       = state_q;
    clr_ptr_d     = clr_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    phase_d       = phase_q;
    entry_count_d = entry_count_q;
    load_err_d    = load_err_q;
    tag_d         = tag_q;
    in1_d         = in1_q;
    mem_we        = 1'b0;
    mem_waddr     = clr_ptr_q;
    mem_wdata     = '0;

    if (ld_restart_i) begin
      // Restart wins over any coincident beat; nothing is written this cycle.
      state_d       = StClear;
      clr_ptr_d     = '0;
      wr_ptr_d      = '0;
      phase_d       = 2'd0;
      entry_count_d = '0;
      load_err_d    = 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          mem_we = 1'b1;
          if (clr_ptr_q == LastIdx) begin
            state_d  = StLoad;
            phase_d  = 2'd0;
            wr_ptr_d = '0;
          end else begin
            clr_ptr_d = clr_ptr_q + AW'(1);
          end
        end

        StLoad: begin
          if (hs) begin
            unique case (phase_q)
              2'd0: begin
                tag_d = ld_data_i[TagW-1:0];
                if (ld_last_i) begin
                  state_d    = StDone;
                  load_err_d = 1'b1;
                  phase_d    = 2'd0;
                end else begin
                  phase_d = 2'd1;
                end
              end
              2'd1: begin
                in1_d = ld_data_i;
                if (ld_last_i) begin
                  state_d    = StDone;
                  load_err_d = 1'b1;
                  phase_d    = 2'd0;
                end else begin
                  phase_d = 2'd2;
                end
              end
              2'd2: begin
                mem_we        = 1'b1;
                mem_waddr     = wr_ptr_q;
                mem_wdata     = {tag_q, in1_q, ld_data_i};
                entry_count_d = entry_count_q + (AW + 1)'(1);
                phase_d       = 2'd0;
                // Full store ends the stream; wr_ptr stays on the last entry.
                if (wr_ptr_q != LastIdx) begin
                  wr_ptr_d = wr_ptr_q + AW'(1);
                end
                if (ld_last_i || (wr_ptr_q == LastIdx)) begin
                  state_d = StDone;
                end
              end
              default: phase_d = 2'd0;
            endcase
          end
        end

        StDone: ;

        default: state_d = StClear;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StClear;
      clr_ptr_q     <= '0;
      wr_ptr_q      <= '0;
      phase_q       <= 2'd0;
      entry_count_q <= '0;
      load_err_q    <= 1'b0;
      tag_q         <= '0;
      in1_q         <= '0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      phase_q       <= phase_d;
      entry_count_q <= entry_count_d;
      load_err_q    <= load_err_d;
      tag_q         <= tag_d;
      in1_q         <= in1_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_uop_store.sv
// Self-checking bench for uop_store: queue-based reference model compared every cycle,
// plus directed literal expectations.
`timescale 1ns / 1ps

module tb_uop_store;

  localparam int SIZE = 128;
  localparam int M    = 2;
  localparam int W    = 2 * M + 64;
  localparam int AW   = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] uop_addr = '0;
  logic [W-1:0]  uop;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [31:0]   ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_restart = 1'b0;
  logic          init_done;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   entry_count;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  uop_store dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .uop_addr_i   (uop_addr),
    .uop_o        (uop),
    .ld_valid_i   (ld_valid),
    .ld_ready_o   (ld_ready),
    .ld_data_i    (ld_data),
    .ld_last_i    (ld_last),
    .ld_restart_i (ld_restart),
    .init_done_o  (init_done),
    .load_done_o  (load_done),
    .load_err_o   (load_err),
    .entry_count_o(entry_count)
  );

  // Reference model: clear countdown, queue of pending beats, entry array.
  int          m_clr_left;
  bit          m_done, m_err, m_ready;
  int          m_count;
  logic [31:0] m_beats[$];
  logic [31:0] m_b0;
  logic [W-1:0] m_mem[SIZE];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_clr_left = SIZE;
      m_done = 1'b0;
      m_err = 1'b0;
      m_count = 0;
      m_beats.delete();
      foreach (m_mem[i]) m_mem[i] = '0;
    end else begin
      m_ready = (m_clr_left == 0) && !m_done;
      if (ld_restart) begin
        m_clr_left = SIZE;
        m_done = 1'b0;
        m_err = 1'b0;
        m_count = 0;
        m_beats.delete();
        foreach (m_mem[i]) m_mem[i] = '0;
      end else if (m_clr_left > 0) begin
        m_clr_left = m_clr_left - 1;
      end else if (m_ready && ld_valid) begin
        m_beats.push_back(ld_data);
        if (m_beats.size() == 3) begin
          m_b0 = m_beats[0];
          m_mem[m_count] = {m_b0[2*M-1:0], m_beats[1], m_beats[2]};
          m_count = m_count + 1;
          m_beats.delete();
          if (ld_last || m_count == SIZE) m_done = 1'b1;
        end else if (ld_last) begin
          m_beats.delete();
          m_done = 1'b1;
          m_err = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [W-1:0] exp_uop;
      exp_uop = (m_clr_left > 0) ? '0 : m_mem[uop_addr];
      check("cycle", {uop, ld_ready, init_done, load_done, load_err, entry_count},
            {exp_uop, (m_clr_left == 0) && !m_done, m_clr_left == 0, m_done, m_err,
             (AW + 1)'(m_count)});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < SIZE + 8) begin
      step();
      n++;
    end
    if (!init_done) begin
      n_total++;
      $display("FAIL init_timeout: init_done=%b required 1", init_done);
    end
  endtask

  task automatic restart_init();
    ld_restart = 1'b1;
    step();
    ld_restart = 1'b0;
    wait_init();
  endtask

  // Leaves ld_valid high so consecutive calls stream back-to-back.
  task automatic beat(input logic [31:0] d, input logic last);
    int n = 0;
    ld_valid = 1'b1;
    ld_data = d;
    ld_last = last;
    while (!ld_ready && n < 20) begin
      step();
      n++;
    end
    if (!ld_ready) begin
      n_total++;
      $display("FAIL beat_timeout: ld_ready=%b required 1", ld_ready);
    end
    step();
    ld_last = 1'b0;
  endtask

  task automatic peek(input int a, input string name, input logic [W-1:0] exp);
    uop_addr = AW'(a);
    #1;
    check(name, uop, exp);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b1;
    check("rst_ready", ld_ready, 0);
    check("rst_init", init_done, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    check("rst_count", entry_count, 0);
    check("rst_uop", uop, 0);
    reset = 1'b0;

    // Clear takes exactly SIZE edges.
    repeat (SIZE - 1) step();
    check("clr_init_127", init_done, 0);
    step();
    check("clr_init_128", init_done, 1);
    check("clr_ready_128", ld_ready, 1);

    // Single entry, streamed back-to-back.
    beat(32'hA, 1'b0);
    beat(32'h25270004, 1'b0);
    beat(32'h25270005, 1'b1);
    ld_valid = 1'b0;
    peek(0, "one_uop", 68'hA_25270004_25270005);
    check("one_count", entry_count, 1);
    check("one_done", load_done, 1);
    check("one_err", load_err, 0);

    // Same stream with ld_valid toggling every cycle.
    restart_init();
    beat(32'hA, 1'b0);
    ld_valid = 1'b0;
    step();
    beat(32'h25270004, 1'b0);
    ld_valid = 1'b0;
    step();
    check("tog_count_mid", entry_count, 0);
    beat(32'h25270005, 1'b1);
    ld_valid = 1'b0;
    step();
    peek(0, "tog_uop", 68'hA_25270004_25270005);
    check("tog_count", entry_count, 1);
    check("tog_done", load_done, 1);

    // Two full entries, then ld_last on beat 1 of the third.
    restart_init();
    beat(32'h6, 1'b0);
    beat(32'h11111111, 1'b0);
    beat(32'h22222222, 1'b0);
    beat(32'h9, 1'b0);
    beat(32'h33333333, 1'b0);
    beat(32'h44444444, 1'b0);
    beat(32'h3, 1'b0);
    beat(32'h55555555, 1'b1);
    ld_valid = 1'b0;
    step();
    check("part_count", entry_count, 2);
    check("part_err", load_err, 1);
    check("part_done", load_done, 1);
    peek(0, "part_a0", 68'h6_11111111_22222222);
    peek(1, "part_a1", 68'h9_33333333_44444444);
    peek(2, "part_a2", 68'h0);

    // Fill the whole store; upper bits of beat 0 must be ignored.
    restart_init();
    for (int e = 0; e < SIZE; e++) begin
      beat({28'hABCDEF0, 4'(e)}, 1'b0);
      beat(32'h10000000 + 32'(e), 1'b0);
      beat(32'h20000000 + 32'(e), 1'b0);
    end
    check("full_done", load_done, 1);
    check("full_ready", ld_ready, 0);
    check("full_count", entry_count, 128);
    ld_data = 32'hFFFF_FFFF;
    repeat (3) step();
    ld_valid = 1'b0;
    check("full_count_hold", entry_count, 128);
    check("full_err", load_err, 0);
    peek(127, "full_a127", 68'hF_1000007F_2000007F);
    peek(0, "full_a0", 68'h0_10000000_20000000);
    peek(18, "full_a18", 68'h2_10000012_20000012);

    // Restart mid-entry, coincident with a valid beat.
    restart_init();
    beat(32'h7, 1'b0);
    ld_data = 32'hDEAD_BEEF;
    ld_restart = 1'b1;
    step();
    ld_restart = 1'b0;
    ld_valid = 1'b0;
    check("rs_init", init_done, 0);
    check("rs_count", entry_count, 0);
    for (int i = 0; i < SIZE - 1; i++) begin
      uop_addr = AW'(SIZE - 1 - i);
      step();
    end
    check("rs_init_127", init_done, 0);
    step();
    check("rs_init_128", init_done, 1);
    for (int a = 0; a < SIZE; a++) peek(a, "rs_zero", 68'h0);
    check("rs_count_after", entry_count, 0);

    // Asynchronous reset in the middle of loading.
    beat(32'h5, 1'b0);
    beat(32'h12345678, 1'b0);
    ld_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("ar_ready", ld_ready, 0);
    check("ar_init", init_done, 0);
    check("ar_uop", uop, 0);
    check("ar_count", entry_count, 0);
    step();
    reset = 1'b0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uop_store.md
# uop_store

Microcode store answering the fetch side of the microcode unit. The microcode unit drives `uop_addr` and consumes `uop`; this block returns the addressed uop combinationally. On reset it zero-fills its array. It then accepts a 32-bit load stream and packs every three beats into one uop entry.

## Interface
- `UOP_BUF_SIZE`, default `UOP_BUF_SIZE` define (128): number of uop entries.
- `MAX_PREDICT_DEPTH_BITS`, default `MAX_PREDICT_DEPTH_BITS` define (2): width of each branch tag.
- `UOP_BUF_WIDTH`, default `UOP_BUF_WIDTH` define (`2*MAX_PREDICT_DEPTH_BITS+64`): entry width.
- `AW`, default `$clog2(UOP_BUF_SIZE)`: address width.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `uop_addr` in AW: fetch address from the microcode unit.
- `uop` out UOP_BUF_WIDTH: entry at `uop_addr`, combinational.
- `ld_valid` in 1: load beat valid.
- `ld_ready` out 1: store accepts a beat.
- `ld_data` in 32: load beat.
- `ld_last` in 1: final beat of the stream.
- `ld_restart` in 1: single-cycle pulse; re-clears the store and restarts loading.
- `init_done` out 1: clear finished; `uop` is meaningful.
- `load_done` out 1: stream terminated (last, full, or error).
- `load_err` out 1: stream ended on a partial entry.
- `entry_count` out AW+1: number of entries written since the last clear.

## Operation
- Entry format, MSB to LSB: {tag1, tag2, in1[31:0], in2[31:0]}.
  - Beat 0 supplies tag1 in `ld_data[2M-1:M]` and tag2 in `ld_data[M-1:0]`, where M = MAX_PREDICT_DEPTH_BITS. Upper bits of beat 0 are ignored.
  - Beat 1 supplies in1; beat 2 supplies in2.
- States:
  - CLEAR: `clr_ptr` walks 0..SIZE-1, writing 0 to one entry per cycle. After writing SIZE-1 the store moves to LOAD, with `phase`=0 and `wr_ptr`=0.
  - LOAD: `ld_ready`=1. A handshake (`ld_valid & ld_ready`) advances `phase` 0→1→2→0.
    - Beats 0 and 1 are held in staging registers.
    - On a phase-2 handshake the full entry is written at `wr_ptr`; `wr_ptr` and `entry_count` increment.
  - DONE: `ld_ready`=0, `load_done`=1. The store holds until `ld_restart` or reset.
- Transitions out of LOAD:
  - Phase-2 beat with `ld_last`: write the entry, then go to DONE.
  - Phase-2 beat that writes entry SIZE-1 (store full): write it, then go to DONE, regardless of `ld_last`.
  - Beat with `ld_last` at phase 0 or 1: discard the partial entry, set `load_err`, go to DONE. Entries already written are kept.
- `ld_restart` in any state goes to CLEAR at the next edge:
  - `clr_ptr`=0; `entry_count`, `load_err`, `phase` cleared.
  - If a handshake coincides with `ld_restart`, restart wins and the beat is discarded with no write.
- Read path: `uop` = 0 while in CLEAR; otherwise `uop` = mem[`uop_addr`]. Every address in range is valid.
- Widths: `entry_count` saturates naturally at SIZE, since DONE is entered on full. `wr_ptr` never wraps.

## Timing
- Reset asserted: state=CLEAR, `clr_ptr`=0, `phase`=0, `wr_ptr`=0.
  - Outputs: `ld_ready`=0, `init_done`=0, `load_done`=0, `load_err`=0, `entry_count`=0, `uop`=0.
  - Array contents are unspecified until CLEAR completes.
- CLEAR takes exactly SIZE cycles.
  - With reset deasserted before edge 1, `init_done` and `ld_ready` go high after edge SIZE.
  - The first beat can be accepted at edge SIZE+1.
- Load throughput: one beat per cycle, so one entry per 3 cycles with no bubbles. `ld_ready` does not depend on `ld_valid`.
- Write-to-read latency: a write lands at the phase-2 edge. `uop` for that address shows the new value in the same cycle after that edge, i.e. zero cycles after the write edge.
- Fetch latency: combinational; no clock between `uop_addr` and `uop`.
- `load_done` and `load_err` rise on the edge that enters DONE. Both fall on the edge that enters CLEAR.
- Reset mid-LOAD: immediate asynchronous return to CLEAR, with all outputs at their reset values.

## Test plan
- Reset, then hold `uop_addr`=0 for SIZE cycles → `uop`=0 and `init_done`=0 throughout; `init_done`=1 and `ld_ready`=1 after edge 128.
- Load beats 'hA, 'h25270004, 'h25270005, with `ld_last` on the third (M=2) → `uop_addr`=0 reads 68'hA_25270004_25270005; `entry_count`=1; `load_done`=1; `load_err`=0.
- Same stream with `ld_valid` toggling 1/0 every cycle → identical result; no beat lost or duplicated; `entry_count` increments only on phase-2 handshakes.
- Two full entries, then `ld_last` on beat 1 of the third → `entry_count`=2, `load_err`=1; address 2 still reads 0.
- Stream 384 beats without `ld_last` → DONE after entry 127; `entry_count`=128; `ld_ready`=0; the 385th beat is not accepted; address 127 holds the last triple.
- Pulse `ld_restart` mid-entry, coincident with a valid beat → CLEAR for 128 cycles with `uop`=0 during it; afterwards all entries read 0 and `entry_count`=0.
